// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and defaults for the data-memory bus controller.
// State encodings are fixed so they line up with the legacy 2-bit DMEM_ST_* values.
package dmem_bus_ctrl_pkg;

  localparam int unsigned DmemAddrW      = 32;
  localparam int unsigned DmemDataW      = 32;
  localparam int unsigned DmemTimeoutCyc = 16;
  localparam logic [31:0] DmemErrData    = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } dmem_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Request/acknowledge memory bus between the controller (master) and memory (slave).
interface dmem_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/dmem_bus_ctrl_timeout_ctr.sv
// Cycle counter for an outstanding bus request; expires on the last allowed BUSY cycle.
module dmem_bus_ctrl_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_expire = (r_cnt == CntLast);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data access controller: turns a single-cycle load/store into a req/ack bus
// transaction, stalls the pipeline until it completes, and flags misalignment or timeout.
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DmemAddrW,
  parameter int unsigned       DATA_W      = DmemDataW,
  parameter int unsigned       TIMEOUT_CYC = DmemTimeoutCyc,
  parameter logic [DATA_W-1:0] ERR_DATA    = DmemErrData
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_acc_valid,
  input  logic              i_acc_we,
  input  logic [ADDR_W-1:0] i_acc_addr,
  input  logic [DATA_W-1:0] i_acc_wdata,
  output logic              o_stall_m,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_err_flag,
  dmem_bus_ctrl_if.master   bus
);

  dmem_state_e r_state;
  dmem_state_e w_state_next;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_read_data;
  logic              r_err_flag;

  logic w_aligned;
  logic w_launch;
  logic w_misalign;
  logic w_ack_done;
  logic w_timeout;
  logic w_expire;
  logic w_ctr_clr;
  logic w_ctr_en;

  dmem_bus_ctrl_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_ctr_clr),
    .i_en     (w_ctr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_acc_valid) begin
          w_state_next = is_word_aligned(i_acc_addr[1:0]) ? StBusy : StDone;
        end
      end
      StBusy: begin
        if (bus.ack || w_expire) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_aligned  = is_word_aligned(i_acc_addr[1:0]);
    w_launch   = 1'b0;
    w_misalign = 1'b0;
    w_ack_done = 1'b0;
    w_timeout  = 1'b0;
    w_ctr_en   = 1'b0;
    w_ctr_clr  = (r_state != StBusy);
    // DONE is the only state that lets the pipeline advance.
    o_stall_m  = i_acc_valid && (r_state != StDone);
    unique case (r_state)
      StIdle: begin
        w_launch   = i_acc_valid && w_aligned;
        w_misalign = i_acc_valid && !w_aligned;
      end
      StBusy: begin
        w_ctr_en   = 1'b1;
        w_ack_done = bus.ack;
        // An ack on the expiry cycle still completes the access cleanly.
        w_timeout  = !bus.ack && w_expire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_read_data <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= i_acc_we;
        r_bus_addr  <= i_acc_addr;
        r_bus_wdata <= i_acc_wdata;
      end
      if (w_ack_done || w_timeout) begin
        r_bus_req <= 1'b0;
      end
      if (w_ack_done && !r_bus_we) begin
        r_read_data <= bus.rdata;
      end
      if (w_misalign || w_timeout) begin
        r_read_data <= ERR_DATA;
        r_err_flag  <= 1'b1;
      end
    end
  end

  assign bus.req     = r_bus_req;
  assign bus.we      = r_bus_we;
  assign bus.addr    = r_bus_addr;
  assign bus.wdata   = r_bus_wdata;
  assign o_read_data = r_read_data;
  assign o_err_flag  = r_err_flag;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench: transaction-level timeline model plus a bench-side memory,
// compared against the controller every cycle, with a few literal pins.
module tb_dmem_bus_ctrl;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acc_valid;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        stall_m;
  logic [31:0] read_data;
  logic        err_flag;

  always #5 clk = ~clk;

  dmem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  dmem_bus_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO),
    .ERR_DATA    (ERR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_acc_valid (acc_valid),
    .i_acc_we    (acc_we),
    .i_acc_addr  (acc_addr),
    .i_acc_wdata (acc_wdata),
    .o_stall_m   (stall_m),
    .o_read_data (read_data),
    .o_err_flag  (err_flag),
    .bus         (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle, set by the driver from the transaction plan.
  logic        e_stall, e_req, e_we, e_err;
  logic [31:0] e_addr, e_wdata, e_rdata;
  bit          chk_en = 1'b0;
  int          stall_cnt = 0;
  int          req_cnt   = 0;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stallM",   32'(stall_m),       32'(e_stall));
      check("busReq",   32'(bus_if.req),    32'(e_req));
      check("busWe",    32'(bus_if.we),     32'(e_we));
      check("busAddr",  bus_if.addr,        e_addr);
      check("busWdata", bus_if.wdata,       e_wdata);
      check("readData", read_data,          e_rdata);
      check("errFlag",  32'(err_flag),      32'(e_err));
      if (stall_m === 1'b1) stall_cnt++;
      if (bus_if.req === 1'b1) req_cnt++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic spurious_ack();
    bus_if.ack   = 1'($urandom_range(0, 1));
    bus_if.rdata = $urandom;
  endtask

  task automatic expect_reset_values();
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_err = 1'b0;
    e_addr  = '0;   e_wdata = '0; e_rdata = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      acc_valid = 1'b0;
      acc_we    = 1'($urandom_range(0, 1));
      acc_addr  = $urandom;
      acc_wdata = $urandom;
      spurious_ack();
      e_stall = 1'b0;
      e_req   = 1'b0;
    end
  endtask

  // d = BUSY-cycle index on which memory acks; negative means never.
  task automatic do_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d);
    logic [31:0] rd;
    bit          acked;
    next_cycle();
    acc_valid = 1'b1;
    acc_we    = we;
    acc_addr  = addr;
    acc_wdata = wdata;
    spurious_ack();
    e_stall = 1'b1;
    e_req   = 1'b0;
    if (addr[1:0] != 2'b00) begin
      next_cycle();
      spurious_ack();
      e_stall = 1'b0;
      e_rdata = ERR;
      e_err   = 1'b1;
      return;
    end
    if (mem.exists(addr)) rd = mem[addr];
    else rd = $urandom;
    acked = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      next_cycle();
      acc_addr     = $urandom;
      acc_wdata    = $urandom;
      bus_if.ack   = (k == d);
      bus_if.rdata = (k == d) ? rd : $urandom;
      e_stall = 1'b1;
      e_req   = 1'b1;
      e_we    = we;
      e_addr  = addr;
      e_wdata = wdata;
      if (k == d) begin
        acked = 1'b1;
        break;
      end
    end
    next_cycle();
    spurious_ack();
    e_stall = 1'b0;
    e_req   = 1'b0;
    if (acked) begin
      if (we) mem[addr] = wdata;
      else begin
        mem[addr] = rd;
        e_rdata   = rd;
      end
    end else begin
      e_rdata = ERR;
      e_err   = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sb, rb;
    rst_n = 1'b0;
    acc_valid = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    bus_if.ack = 1'b0; bus_if.rdata = '0;
    expect_reset_values();
    chk_en = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_readData", read_data, 32'h0);
    check("rst_busReq", 32'(bus_if.req), 32'h0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Zero-wait load at 0x40.
    mem[32'h40] = 32'h12345678;
    sb = stall_cnt; rb = req_cnt;
    do_acc(1'b0, 32'h40, 32'h0, 0);
    check("ld40_data", read_data, 32'h12345678);
    idle_cycles(1);
    check("ld40_stall", 32'(stall_cnt - sb), 32'd2);
    check("ld40_req",   32'(req_cnt - rb),   32'd1);

    // Store with ack on the fifth BUSY cycle.
    sb = stall_cnt; rb = req_cnt;
    do_acc(1'b1, 32'h44, 32'hCAFEF00D, 4);
    check("st44_addr",  bus_if.addr,  32'h44);
    check("st44_wdata", bus_if.wdata, 32'hCAFEF00D);
    check("st44_we",    32'(bus_if.we), 32'h1);
    idle_cycles(1);
    check("st44_stall", 32'(stall_cnt - sb), 32'd6);
    check("st44_req",   32'(req_cnt - rb),   32'd5);
    check("st44_noerr", 32'(err_flag), 32'h0);

    // Load that is never acked.
    sb = stall_cnt; rb = req_cnt;
    do_acc(1'b0, 32'h48, 32'h0, -1);
    check("to_data", read_data, ERR);
    check("to_err",  32'(err_flag), 32'h1);
    idle_cycles(1);
    check("to_stall", 32'(stall_cnt - sb), 32'd17);
    check("to_req",   32'(req_cnt - rb),   32'd16);

    // Reset in the middle of a bus transaction.
    next_cycle();
    acc_valid = 1'b1; acc_we = 1'b0; acc_addr = 32'h100; acc_wdata = '0;
    bus_if.ack = 1'b0;
    e_stall = 1'b1; e_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus_if.ack = 1'b0;
      e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h100; e_wdata = '0;
    end
    next_cycle();
    rst_n = 1'b0;
    acc_valid = 1'b0;
    expect_reset_values();
    #1;
    check("rst_mid_req", 32'(bus_if.req), 32'h0);
    check("rst_mid_err", 32'(err_flag), 32'h0);
    idle_cycles(2);
    rst_n = 1'b1;

    // Back-to-back store then load at 0x80.
    sb = stall_cnt; rb = req_cnt;
    do_acc(1'b1, 32'h80, 32'hA5A50001, 2);
    do_acc(1'b0, 32'h80, 32'h0, 1);
    check("b2b_data", read_data, 32'hA5A50001);
    idle_cycles(1);
    check("b2b_stall", 32'(stall_cnt - sb), 32'd7);
    check("b2b_req",   32'(req_cnt - rb),   32'd5);

    // Misaligned load.
    sb = stall_cnt; rb = req_cnt;
    do_acc(1'b0, 32'h41, 32'h0, 0);
    check("mis_data", read_data, ERR);
    check("mis_err",  32'(err_flag), 32'h1);
    idle_cycles(1);
    check("mis_stall", 32'(stall_cnt - sb), 32'd1);
    check("mis_req",   32'(req_cnt - rb),   32'd0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int          d;
      idle_cycles(int'($urandom_range(0, 2)));
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 18));
      do_acc(1'($urandom_range(0, 1)), a, $urandom, d);
    end
    idle_cycles(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
